// File: rtl/fetch_queue_if.sv
// Fetch-queue handshake bundle between IF/instruction memory and ID.
// The master modport is the IF/ID side; the slave modport is the queue itself.
interface fetch_queue_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PC_W  = 32,
  parameter int unsigned IW    = 32
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic            if_valid;
  logic [PC_W-1:0] if_pc;
  logic [IW-1:0]   if_instr;
  logic            if_stall;
  logic            flush;
  logic            id_valid;
  logic [PC_W-1:0] id_pc;
  logic [IW-1:0]   id_instr;
  logic            id_ready;
  logic [CW-1:0]   count;

  modport master (
    output if_valid, if_pc, if_instr, flush, id_ready,
    input  if_stall, id_valid, id_pc, id_instr, count
  );

  modport slave (
    input  if_valid, if_pc, if_instr, flush, id_ready,
    output if_stall, id_valid, id_pc, id_instr, count
  );
endinterface

// File: rtl/fetch_queue.sv
// Circular instruction fetch queue between IF and ID with flush and full back-pressure.
// Optional zero-latency empty-queue bypass is enabled by defining FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PC_W  = 32,
  parameter int unsigned IW    = 32
) (
  input  logic          clk_cpu,
  input  logic          rst,
  fetch_queue_if.slave  bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [IW-1:0] Nop = IW'(32'h0000_0013);

  logic [PC_W-1:0] r_pc_mem    [DEPTH];
  logic [IW-1:0]   r_instr_mem [DEPTH];
  logic [AW-1:0]   r_wp;
  logic [AW-1:0]   r_rp;
  logic [CW-1:0]   r_count;

  logic w_full;
  logic w_empty;
  logic w_bypass;
  logic w_push;
  logic w_pop;
  logic w_id_valid;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

`ifdef FETCH_QUEUE_BYPASS_EN
  assign w_bypass = w_empty & bus.if_valid & ~bus.flush;
`else
  assign w_bypass = 1'b0;
`endif

  // A bypassed fetch that ID takes immediately never occupies a slot.
  assign w_push     = bus.if_valid & ~w_full & ~bus.flush & ~(w_bypass & bus.id_ready);
  assign w_pop      = ~w_empty & ~bus.flush & bus.id_ready;
  assign w_id_valid = (~w_empty & ~bus.flush) | w_bypass;

  assign bus.if_stall = w_full;
  assign bus.id_valid = w_id_valid;
  assign bus.count    = r_count;

  always_comb begin
    bus.id_pc    = '0;
    bus.id_instr = Nop;
    if (w_bypass) begin
      bus.id_pc    = bus.if_pc;
      bus.id_instr = bus.if_instr;
    end else if (w_id_valid) begin
      bus.id_pc    = r_pc_mem[r_rp];
      bus.id_instr = r_instr_mem[r_rp];
    end
  end

  // Storage is deliberately left unreset; only pointers and count define validity.
  always_ff @(posedge clk_cpu) begin
    if (w_push) begin
      r_pc_mem[r_wp]    <= bus.if_pc;
      r_instr_mem[r_wp] <= bus.if_instr;
    end
  end

  always_ff @(posedge clk_cpu or posedge rst) begin
    if (rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else if (bus.flush) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (default build, no bypass).
module tb_fetch_queue;
  logic clk_cpu = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  fetch_queue_if #(.DEPTH(4), .PC_W(32), .IW(32)) bus ();

  fetch_queue #(.DEPTH(4), .PC_W(32), .IW(32)) dut (
    .clk_cpu (clk_cpu),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 clk_cpu = ~clk_cpu;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
    bus.if_valid = v;
    bus.if_pc    = pc;
    bus.if_instr = instr_of(pc);
    bus.id_ready = rdy;
    bus.flush    = fl;
  endtask

  task automatic tick();
    @(posedge clk_cpu);
    #1;
  endtask

  initial begin
    int          q[$];
    int          sz;
    logic [31:0] exp_pc;
    logic [31:0] wpc;
    logic        rdy;

    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #2;
    chk("reset_id_valid", 32'(bus.id_valid), 32'd0);
    chk("reset_id_pc",    bus.id_pc,          32'd0);
    chk("reset_id_instr", bus.id_instr,       32'h0000_0013);
    chk("reset_count",    32'(bus.count),     32'd0);
    chk("reset_if_stall", 32'(bus.if_stall),  32'd0);
    tick();
    rst = 1'b0;

    // Streaming: one per cycle, one cycle latency.
    for (int k = 0; k <= 8; k++) begin
      drive(k < 8, 32'h3000 + 32'(4 * k), 1'b1, 1'b0);
      #1;
      chk("stream_count", 32'(bus.count), (k > 0) ? 32'd1 : 32'd0);
      chk("stream_valid", 32'(bus.id_valid), (k > 0) ? 32'd1 : 32'd0);
      if (k > 0) begin
        chk("stream_pc",    bus.id_pc,    32'h3000 + 32'(4 * (k - 1)));
        chk("stream_instr", bus.id_instr, instr_of(32'h3000 + 32'(4 * (k - 1))));
      end
      tick();
    end
    chk("stream_drained", 32'(bus.count), 32'd0);

    // Fill to full with ID stalled.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h3000 + 32'(4 * i), 1'b0, 1'b0);
      #1;
      chk("fill_count", 32'(bus.count), 32'(i));
      chk("fill_stall", 32'(bus.if_stall), 32'd0);
      tick();
    end
    // Full with simultaneous pop: incoming 0x3010 dropped.
    drive(1'b1, 32'h3010, 1'b1, 1'b0);
    #1;
    chk("full_count", 32'(bus.count),    32'd4);
    chk("full_stall", 32'(bus.if_stall), 32'd1);
    chk("full_head",  bus.id_pc,         32'h3000);
    tick();
    chk("popfull_count", 32'(bus.count),    32'd3);
    chk("popfull_stall", 32'(bus.if_stall), 32'd0);
    chk("popfull_head",  bus.id_pc,         32'h3004);
    drive(1'b1, 32'h3010, 1'b0, 1'b0);
    tick();
    chk("repush_count", 32'(bus.count),    32'd4);
    chk("repush_stall", 32'(bus.if_stall), 32'd1);
    for (int j = 0; j < 4; j++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      #1;
      chk("drain_valid", 32'(bus.id_valid), 32'd1);
      chk("drain_pc",    bus.id_pc,          32'h3004 + 32'(4 * j));
      chk("drain_instr", bus.id_instr,       instr_of(32'h3004 + 32'(4 * j)));
      tick();
    end
    chk("drain_empty", 32'(bus.count), 32'd0);

    // Flush with 3 queued and a concurrent fetch.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h3040 + 32'(4 * i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 32'h3100, 1'b1, 1'b1);
    #1;
    chk("flush_count_pre", 32'(bus.count),    32'd3);
    chk("flush_valid",     32'(bus.id_valid), 32'd0);
    chk("flush_instr",     bus.id_instr,      32'h0000_0013);
    tick();
    chk("flush_count_post", 32'(bus.count),    32'd0);
    chk("flush_valid_post", 32'(bus.id_valid), 32'd0);
    drive(1'b1, 32'h3100, 1'b0, 1'b0);
    tick();
    chk("postflush_count", 32'(bus.count), 32'd1);
    chk("postflush_valid", 32'(bus.id_valid), 32'd1);
    chk("postflush_pc",    bus.id_pc,          32'h3100);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    chk("postflush_empty", 32'(bus.count), 32'd0);

    // Asynchronous reset mid-cycle with a full queue.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h3200 + 32'(4 * i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("prerst_count", 32'(bus.count), 32'd4);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(bus.id_valid), 32'd0);
    chk("arst_instr", bus.id_instr,       32'h0000_0013);
    chk("arst_pc",    bus.id_pc,          32'd0);
    chk("arst_count", 32'(bus.count),     32'd0);
    chk("arst_stall", 32'(bus.if_stall),  32'd0);
    #1;
    rst = 1'b0;
    tick();

    // Wrap-around against a scoreboard with random id_ready.
    wpc = 32'h3400;
    for (int c = 0; c < 20; c++) begin
      rdy = 1'($urandom_range(0, 1));
      drive(1'b1, wpc, rdy, 1'b0);
      #1;
      sz = q.size();
      chk("wrap_count", 32'(bus.count),    32'(sz));
      chk("wrap_valid", 32'(bus.id_valid), (sz != 0) ? 32'd1 : 32'd0);
      chk("wrap_stall", 32'(bus.if_stall), (sz == 4) ? 32'd1 : 32'd0);
      if (sz != 0) begin
        chk("wrap_pc",    bus.id_pc,    32'(q[0]));
        chk("wrap_instr", bus.id_instr, instr_of(32'(q[0])));
        if (rdy) exp_pc = 32'(q.pop_front());
      end
      if (sz < 4) begin
        q.push_back(int'(wpc));
        wpc = wpc + 32'd4;
      end
      tick();
    end
    for (int c = 0; c < 6; c++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      #1;
      sz = q.size();
      chk("wdrain_count", 32'(bus.count), 32'(sz));
      if (sz != 0) begin
        chk("wdrain_pc", bus.id_pc, 32'(q[0]));
        exp_pc = 32'(q.pop_front());
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch queue between the IF stage (PC register) and the ID stage. Each cycle it captures the (PC, instruction word) pair presented by IF and instruction memory into a small circular FIFO and delivers entries in order to ID with a valid/ready handshake. It back-pressures IF through `if_stall` when full and discards all buffered fetches on a taken branch.

## Interface
- `DEPTH`, 4: number of entries; power of two, ≥ 2
- `PC_W`, 32: PC width
- `IW`, 32: instruction width
- `clk_cpu`  in  1  CPU clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `if_valid`  in  1  IF presents a valid fetch this cycle
- `if_pc`  in  PC_W  PC of the presented fetch (IF `pcd`)
- `if_instr`  in  IW  instruction word read at `if_pc`
- `if_stall`  out  1  hold IF PC; wired to IF `stall`
- `flush`  in  1  taken branch / redirect (same signal as IF `PCSrc`)
- `id_valid`  out  1  head entry valid for ID
- `id_pc`  out  PC_W  PC of head entry
- `id_instr`  out  IW  instruction of head entry
- `id_ready`  in  1  ID accepts head entry this cycle
- `count`  out  $clog2(DEPTH)+1  number of stored entries

## Operation
- Storage: `DEPTH`-entry array of {pc, instr}; write pointer `wp`, read pointer `rp`, each $clog2(DEPTH) bits, wrapping modulo `DEPTH`; `count` register.
- `full` = (`count` == DEPTH); `empty` = (`count` == 0).
- `if_stall` = `full` (combinational from registered `count`).
- push = `if_valid` & ~`full` & ~`flush`; writes `{if_pc, if_instr}` at `wp`, `wp` += 1.
- pop = `id_valid` & `id_ready` & ~`flush`; `rp` += 1.
- `id_valid` = ~`empty` & ~`flush`.
- When `id_valid` = 0: `id_pc` = 0, `id_instr` = 32'h0000_0013 (NOP). Otherwise both driven from entry at `rp`.
- Count update: push only → +1; pop only → −1; both → unchanged; neither → unchanged.
- Push while full is dropped (IF is stalled, so the same PC is re-presented next cycle).
- Pop while empty: impossible, because `id_valid` = 0.
- Flush: on the next edge `wp`, `rp`, and `count` return to 0. A concurrent `if_valid` is discarded, and any concurrent `id_ready` has no effect. Flush has priority over all other events.
- Storage array contents are not reset; only pointers and `count` are reset.

## Timing
- Reset (async, while `rst` = 1):
  - `count` = 0, `wp` = `rp` = 0
  - `id_valid` = 0, `id_pc` = 0, `id_instr` = 32'h0000_0013
  - `if_stall` = 0
- Reset mid-operation: all entries are lost immediately, without waiting for a clock edge.
- Latency, IF → ID (no bypass): a fetch pushed at edge N is visible on `id_*` after edge N, i.e. one cycle later.
- Throughput: 1 entry/cycle sustained when `id_ready` = 1 continuously.
- Full with simultaneous pop: the pop completes, `count` becomes DEPTH−1, and `if_stall` deasserts the following cycle. The incoming fetch in that cycle is dropped and re-presented.
- Flush cycle: `id_valid` = 0 combinationally in the same cycle. The queue is empty from the next cycle, and the first post-branch fetch pushes the cycle after the flush.

## Configuration
- `FETCH_QUEUE_BYPASS_EN` defined: when `empty` & `if_valid` & ~`flush`:
  - `id_valid` = 1, `id_pc` = `if_pc`, `id_instr` = `if_instr` combinationally.
  - If `id_ready` = 1, the entry is consumed and not written, and `count` stays 0.
  - If `id_ready` = 0, the entry is written as a normal push.
  - Zero-cycle latency when empty.
- Not defined: no combinational path from `if_*` to `id_*`; minimum latency is one cycle.

## Test plan
- Reset, then 8 sequential fetches (PC 0x3000..0x301C, instr = PC ^ 0xA5A5_0000) with `id_ready` = 1 → ID sees all 8 in order, one per cycle, `count` ≤ 1; with bypass, `count` stays 0.
- `id_ready` = 0, feed fetches 0x3000, 0x3004, … → `count` reaches 4 and `if_stall` = 1. Release `id_ready` → the first entry out is 0x3000, and no PC is skipped or duplicated.
- Queue full, `id_ready` = 1 and `if_valid` = 1 in the same cycle → `count` = 3 next cycle and the incoming fetch is dropped. It is re-pushed the following cycle and `count` returns to 4.
- 3 entries queued, assert `flush` with `if_valid` = 1 (PC 0x3100) → `id_valid` = 0 that cycle and `count` = 0 next cycle. The next push of 0x3100 appears at ID.
- 4 entries queued, assert `rst` mid-cycle → without waiting for a clock edge, `id_valid` = 0, `id_instr` = 0x0000_0013, `count` = 0, `if_stall` = 0.
- Wrap-around: 20 push/pop cycles with random `id_ready` → ID output order matches the push order across pointer wrap; scoreboard check.
